// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// rtl/pipeline_hazard_ctrl_forward_unit.sv - operand bypass select for one Execute source register
module forward_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [3:0] ra,
    input  logic [3:0] wa_m,
    input  logic [3:0] wa_w,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    output fwd_sel_t   fwd
);

    // The PC is read directly from fetch, so a stale M/W copy must never bypass it
    always_comb begin
        fwd = FWD_RF;
        if (ra != REG_PC) begin
            if (regwrite_m && (ra == wa_m)) begin
                fwd = FWD_M;
            end else if (regwrite_w && (ra == wa_w)) begin
                fwd = FWD_W;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - forwarding, stall/flush decode and memory-wait tracking
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        MemtoRegE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemReqM,
    input  logic        mem_ready,
    input  logic        BranchTakenE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [15:0] stall_count,
    output logic        mem_timeout
);

    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT_CYC - 1);

    fwd_sel_t  fwd_a;
    fwd_sel_t  fwd_b;
    hz_state_t state;
    hz_state_t state_next;
    logic [4:0] wait_cnt;
    logic       memstall;
    logic       lduse;

    forward_unit u_fwd_a (
        .ra         (RA1E),
        .wa_m       (WA3M),
        .wa_w       (WA3W),
        .regwrite_m (RegWriteM),
        .regwrite_w (RegWriteW),
        .fwd        (fwd_a)
    );

    forward_unit u_fwd_b (
        .ra         (RA2E),
        .wa_m       (WA3M),
        .wa_w       (WA3W),
        .regwrite_m (RegWriteM),
        .regwrite_w (RegWriteW),
        .fwd        (fwd_b)
    );

    assign memstall = MemReqM & ~mem_ready;
    assign lduse    = MemtoRegE & ((WA3E == RA1D) | (WA3E == RA2D));

    assign ForwardAE = rst ? 2'b00 : fwd_a;
    assign ForwardBE = rst ? 2'b00 : fwd_b;

    // Memory wait freezes everything and drops the W result; branch flush beats load-use bubble
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            if (memstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lduse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (memstall)  state_next = MEM_WAIT;
            MEM_WAIT: if (!memstall) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= 5'd0;
            mem_timeout <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            if (state == IDLE) begin
                wait_cnt <= 5'd0;
            end else if (wait_cnt != 5'd31) begin
                wait_cnt <= wait_cnt + 5'd1;
            end
            if ((state == MEM_WAIT) && memstall && (wait_cnt >= WAIT_LAST)) begin
                mem_timeout <= 1'b1;
            end
            if (StallF && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        MemtoRegE, RegWriteM, RegWriteW, MemReqM, mem_ready, BranchTakenE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [15:0] stall_count;
    logic        mem_timeout;

    pipeline_hazard_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .MemtoRegE    (MemtoRegE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemReqM      (MemReqM),
        .mem_ready    (mem_ready),
        .BranchTakenE (BranchTakenE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .stall_count  (stall_count),
        .mem_timeout  (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {FA[1:0], FB[1:0], SF, SD, SE, SM, FD, FE, FW}
    typedef struct {
        logic [3:0]  ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic        mtr, rwm, rww, mreq, mrdy, br;
        logic [10:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
                                logic mtr, rwm, rww, mreq, mrdy, br, logic [10:0] exp);
        vec_t v;
        v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
        v.wa3e = wa3e; v.wa3m = wa3m; v.wa3w = wa3w;
        v.mtr = mtr; v.rwm = rwm; v.rww = rww; v.mreq = mreq; v.mrdy = mrdy; v.br = br;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
        WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
        MemtoRegE = v.mtr; RegWriteM = v.rwm; RegWriteW = v.rww;
        MemReqM = v.mreq; mem_ready = v.mrdy; BranchTakenE = v.br;
    endtask

    task automatic idle();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 11'b0));
    endtask

    task automatic set_lduse();
        apply(mk(0, 5, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 0, 11'b0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(0, 0, 3, 0, 0, 3, 3,    0, 1, 1, 0, 1, 0, 11'b10_00_0000_000));
        vecs.push_back(mk(0, 0, 3, 0, 0, 3, 3,    0, 0, 1, 0, 1, 0, 11'b01_00_0000_000));
        vecs.push_back(mk(0, 0, 15, 15, 0, 15, 15, 0, 1, 1, 0, 1, 0, 11'b00_00_0000_000));
        vecs.push_back(mk(0, 0, 2, 7, 0, 7, 2,    0, 1, 1, 0, 1, 0, 11'b01_10_0000_000));
        vecs.push_back(mk(0, 5, 0, 0, 5, 0, 0,    1, 0, 0, 0, 1, 0, 11'b00_00_1100_010));
        vecs.push_back(mk(15, 0, 0, 0, 15, 0, 0,  1, 0, 0, 0, 1, 0, 11'b00_00_1100_010));
        vecs.push_back(mk(0, 5, 0, 0, 5, 0, 0,    0, 0, 0, 0, 1, 0, 11'b00_00_0000_000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1, 11'b00_00_0000_110));
        vecs.push_back(mk(0, 5, 0, 0, 5, 0, 0,    1, 0, 0, 0, 1, 1, 11'b00_00_0000_110));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0, 11'b00_00_1111_001));
        vecs.push_back(mk(0, 5, 3, 0, 5, 3, 0,    1, 1, 0, 1, 0, 1, 11'b10_00_1111_001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1, 0, 11'b00_00_0000_000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 11'b00_00_0000_000));

        // Reset holds every output low even with hazards on the inputs
        rst = 1'b1;
        apply(mk(5, 5, 3, 3, 5, 3, 3, 1, 1, 1, 1, 0, 1, 11'b0));
        #2;
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_stall_count", 32'(stall_count), 32'h0);
        chk("reset_timeout", 32'(mem_timeout), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_hold_outs", 32'(outs()), 32'h0);
        chk("reset_hold_count", 32'(stall_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i]);
            sb_q.push_back(vecs[i].exp);
            #2;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(sb_q.pop_front()));
        end

        // Load-use: single bubble, one counted stall
        do_reset();
        @(negedge clk);
        set_lduse();
        #2;
        chk("lduse_outs", 32'(outs()), 32'(11'b00_00_1100_010));
        @(negedge clk);
        idle();
        #2;
        chk("lduse_count", 32'(stall_count), 32'd1);
        chk("lduse_release", 32'(outs()), 32'h0);

        // Three-cycle memory wait
        @(negedge clk);
        MemReqM = 1'b1;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("memwait_c%0d", k), 32'(outs()), 32'(11'b00_00_1111_001));
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #2;
        chk("memwait_release", 32'(outs()), 32'h0);
        chk("memwait_count", 32'(stall_count), 32'd4);
        @(negedge clk);
        idle();
        #2;
        chk("memwait_idle", 32'(dut.state), 32'(IDLE));

        // Branch held under a two-cycle memory wait
        @(negedge clk);
        MemReqM = 1'b1;
        mem_ready = 1'b0;
        BranchTakenE = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk($sformatf("br_stall_c%0d", k), 32'({FlushD, FlushE}), 32'h0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #2;
        chk("br_after_release", 32'(outs()), 32'(11'b00_00_0000_110));
        chk("br_count", 32'(stall_count), 32'd6);
        @(negedge clk);
        idle();

        // Timeout after a long wait, sticky until reset
        @(negedge clk);
        MemReqM = 1'b1;
        mem_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #2;
            if (k == 10) chk("timeout_early", 32'(mem_timeout), 32'h0);
        end
        chk("timeout_set", 32'(mem_timeout), 32'h1);
        chk("timeout_still_stall", 32'(StallF), 32'h1);
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("timeout_sticky", 32'(mem_timeout), 32'h1);
        chk("timeout_count", 32'(stall_count), 32'd26);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("timeout_cleared", 32'(mem_timeout), 32'h0);
        chk("timeout_count_cleared", 32'(stall_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Reset arriving mid-wait abandons it
        @(negedge clk);
        MemReqM = 1'b1;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midwait_rst_outs", 32'(outs()), 32'h0);
        chk("midwait_rst_state", 32'(dut.state), 32'(IDLE));
        idle();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            chk($sformatf("midwait_after_c%0d", k), 32'(outs()), 32'h0);
        end
        chk("midwait_count", 32'(stall_count), 32'h0);

        // Saturation of the stall counter
        do_reset();
        @(negedge clk);
        set_lduse();
        repeat (16'hFFFE) @(posedge clk);
        @(negedge clk);
        #2;
        chk("sat_preload", 32'(stall_count), 32'hFFFE);
        repeat (5) @(posedge clk);
        @(negedge clk);
        idle();
        #2;
        chk("sat_final", 32'(stall_count), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
